// File: rtl/ifq_pkg.sv
// ifq_pkg: default geometry and constants shared by the instruction fetch queue
package ifq_pkg;
  localparam int IFQ_N = 10;
  localparam int IFQ_DEPTH = 4;
  localparam int IFQ_PW = $clog2(IFQ_DEPTH);
  localparam int IFQ_CW = $clog2(IFQ_DEPTH + 1);
  localparam logic [IFQ_N-1:0] IFQ_NOP = '0;
endpackage

// File: rtl/ifq_ram.sv
// ifq_ram: DEPTH x N register array, one write port, one asynchronous read port, no reset
module ifq_ram #(
  parameter int N = 10,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [N-1:0]  wd,
  input  logic [AW-1:0] ra,
  output logic [N-1:0]  rd
);
  logic [N-1:0] mem [DEPTH];
  // storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end
  assign rd = mem[ra];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: DEPTH-entry instruction FIFO with flush and held IR copy; IFQ_BYPASS_EN adds an empty-queue bypass
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int N = IFQ_N,
  parameter int DEPTH = IFQ_DEPTH
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic [N-1:0]               in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [N-1:0]               ir_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [N-1:0] rd_data;
  logic empty, pop, wr, rd;
  assign empty = count == '0;
  assign in_ready = count != CW'(DEPTH);
  // head presentation and qualification of store/consume events
  always_comb begin
`ifdef IFQ_BYPASS_EN
    out_valid = !empty || in_valid;
    out_data = !empty ? rd_data : in_valid ? in_data : N'(IFQ_NOP);
    wr = in_valid && in_ready && !(empty && out_ready);
`else
    out_valid = !empty;
    out_data = empty ? N'(IFQ_NOP) : rd_data;
    wr = in_valid && in_ready;
`endif
    pop = out_valid && out_ready;
    rd = pop && !empty;
  end
  // occupancy, pointers and last-consumed instruction; reset beats flush beats push/pop
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ir_out <= N'(IFQ_NOP);
    end else begin
      if (pop) ir_out <= out_data;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(wr);
        rd_ptr <= rd_ptr + PW'(rd);
        count <= count + CW'(wr) - CW'(rd);
      end
    end
  end
  ifq_ram #(.N(N), .DEPTH(DEPTH)) u_ram (
    .clk(Clock),
    .we (wr && !flush && !Reset),
    .wa (wr_ptr),
    .wd (in_data),
    .ra (rd_ptr),
    .rd (rd_data)
  );
endmodule
